// File: rtl/fwd_hazard_if.sv
// Issue-stage bus between the decode/issue logic and the forwarding and
// hazard unit. The issue side drives instruction, register-file and
// per-stage result data. The unit returns the forwarded operands, the
// issue/stall decision and its performance counters.
interface fwd_hazard_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NRP    = 2,
    parameter int NSTAGE = 3
);
    logic                   flush;
    logic                   id_valid;
    logic [NRP*AW-1:0]      id_rs;
    logic [AW-1:0]          id_rd;
    logic                   id_we;
    logic                   id_is_load;
    logic [NRP*XLEN-1:0]    rf_data;
    logic [NSTAGE*XLEN-1:0] stage_result;
    logic [NRP*XLEN-1:0]    op_data;
    logic                   stall;
    logic                   issue;
    logic [15:0]            stall_cnt;
    logic [15:0]            fwd_cnt;

    // Issue side: presents instructions and data, consumes the decision.
    modport master (
        output flush, id_valid, id_rs, id_rd, id_we, id_is_load,
        output rf_data, stage_result,
        input  op_data, stall, issue, stall_cnt, fwd_cnt
    );

    // Forwarding/hazard unit side.
    modport slave (
        input  flush, id_valid, id_rs, id_rd, id_we, id_is_load,
        input  rf_data, stage_result,
        output op_data, stall, issue, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection.
// A tag pipeline mirrors the destination of every in-flight write
// (stage 0 = EX, youngest; stage NSTAGE-1 = WB, oldest). Each source port
// picks the youngest matching write. A load that has not yet reached
// LOAD_STAGE holds the presented instruction until its result exists.
// Operand selection and the issue/stall decision are combinational.
// The tag pipeline and the counters are registered.
module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int NRP        = 2,
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    fwd_hazard_if.slave bus
);

    // Reject parameter sets that leave the tag pipeline meaningless.
    generate
        if (NSTAGE < 1) begin : g_bad_nstage
            $error("fwd_hazard_unit: NSTAGE must be at least 1");
        end
        if ((LOAD_STAGE < 0) || (LOAD_STAGE >= NSTAGE)) begin : g_bad_load_stage
            $error("fwd_hazard_unit: LOAD_STAGE must lie in 0..NSTAGE-1");
        end
        if (NRP < 1) begin : g_bad_nrp
            $error("fwd_hazard_unit: NRP must be at least 1");
        end
    endgenerate

    // Tag pipeline: one {valid, rd, is_load} entry per tracked stage.
    logic [NSTAGE-1:0]         tag_valid_r;
    logic [NSTAGE-1:0][AW-1:0] tag_rd_r;
    logic [NSTAGE-1:0]         tag_load_r;

    logic [15:0]               stall_cnt_r;
    logic [15:0]               fwd_cnt_r;

    // Entries are ignored while reset is held. This keeps operands on the
    // register file and keeps stall low before the first reset edge clears
    // the pipeline.
    logic [NSTAGE-1:0]         live_s;
    logic [NRP-1:0]            hit_s;
    logic [NRP-1:0]            ready_s;
    logic [NRP*XLEN-1:0]       op_data_s;
    logic                      stall_s;
    logic                      issue_s;
    logic                      fwd_any_s;

    assign live_s = tag_valid_r & {NSTAGE{rst_n}};

    // Per port: default to register file (zero for r0), youngest match wins.
    always_comb begin
        hit_s     = '0;
        ready_s   = '1;
        op_data_s = '0;
        for (int p = 0; p < NRP; p++) begin
            if (bus.id_rs[p*AW +: AW] == '0) begin
                op_data_s[p*XLEN +: XLEN] = '0;
            end else begin
                op_data_s[p*XLEN +: XLEN] = bus.rf_data[p*XLEN +: XLEN];
            end
            for (int k = 0; k < NSTAGE; k++) begin
                if (!hit_s[p] && live_s[k] &&
                    (bus.id_rs[p*AW +: AW] != '0) &&
                    (tag_rd_r[k] == bus.id_rs[p*AW +: AW])) begin
                    hit_s[p]                  = 1'b1;
                    ready_s[p]                = !(tag_load_r[k] && (k < LOAD_STAGE));
                    op_data_s[p*XLEN +: XLEN] = bus.stage_result[k*XLEN +: XLEN];
                end else begin
                    hit_s[p] = hit_s[p];
                end
            end
        end
    end

    // Flush and reset both suppress the decision outright.
    assign stall_s   = rst_n & bus.id_valid & ~bus.flush & ~(&ready_s);
    assign issue_s   = rst_n & bus.id_valid & ~bus.flush & ~stall_s;
    // Any issued port hit is a forward, because issue implies every winner is ready.
    assign fwd_any_s = |hit_s;

    // Advance the tag pipeline every cycle; flush kills in-flight writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid_r <= '0;
            tag_rd_r    <= '0;
            tag_load_r  <= '0;
        end else begin
            for (int k = NSTAGE - 1; k > 0; k--) begin
                tag_valid_r[k] <= tag_valid_r[k-1] & ~bus.flush;
                tag_rd_r[k]    <= tag_rd_r[k-1];
                tag_load_r[k]  <= tag_load_r[k-1];
            end
            tag_valid_r[0] <= issue_s & bus.id_we & (bus.id_rd != '0);
            tag_rd_r[0]    <= bus.id_rd;
            tag_load_r[0]  <= bus.id_is_load;
        end
    end

    // Saturating stall and forward performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
            fwd_cnt_r   <= 16'h0000;
        end else begin
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (issue_s && fwd_any_s && (fwd_cnt_r != 16'hFFFF)) begin
                fwd_cnt_r <= fwd_cnt_r + 16'h0001;
            end else begin
                fwd_cnt_r <= fwd_cnt_r;
            end
        end
    end

    assign bus.op_data   = op_data_s;
    assign bus.stall     = stall_s;
    assign bus.issue     = issue_s;
    assign bus.stall_cnt = stall_cnt_r;
    assign bus.fwd_cnt   = fwd_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit.
// Instance u_main uses the default parameters and runs directed scenarios.
// Instance u_sat uses a deep pipeline with a late LOAD_STAGE so that it
// stalls on most cycles. That lets it reach counter saturation quickly.
// Stimulus pushes expected values, and the negedge monitor pops and compares them.
module tb_fwd_hazard_unit;

    localparam int XLEN = 32, AW = 5, NRP = 2, NSTAGE = 3, LOAD_STAGE = 1;
    localparam int S_XLEN = 8, S_NRP = 1, S_NSTAGE = 16, S_LOAD = 15;

    localparam logic [3:0] M_OP0 = 4'b0001;
    localparam logic [3:0] M_OP1 = 4'b0010;
    localparam logic [3:0] M_SI  = 4'b0100;
    localparam logic [3:0] M_CNT = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    logic clk        = 1'b0;
    logic main_rst_n = 1'b0;
    logic sat_rst_n  = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [3:0]  mask;
        logic [31:0] op0;
        logic [31:0] op1;
        logic        stall;
        logic        issue;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        logic        rst_n, flush, valid, we, ld;
        logic [4:0]  rs0, rs1, rd;
        logic [31:0] rf0, rf1, sr0, sr1, sr2;
    } stim_t;

    exp_t  q_main[$];
    exp_t  q_sat[$];
    exp_t  mon_e;
    stim_t s;

    fwd_hazard_if #(.XLEN(XLEN), .AW(AW), .NRP(NRP), .NSTAGE(NSTAGE)) main_if ();
    fwd_hazard_if #(.XLEN(S_XLEN), .AW(AW), .NRP(S_NRP), .NSTAGE(S_NSTAGE)) sat_if ();

    fwd_hazard_unit #(.XLEN(XLEN), .AW(AW), .NRP(NRP), .NSTAGE(NSTAGE),
                      .LOAD_STAGE(LOAD_STAGE)) u_main (
        .clk   (clk),
        .rst_n (main_rst_n),
        .bus   (main_if)
    );

    fwd_hazard_unit #(.XLEN(S_XLEN), .AW(AW), .NRP(S_NRP), .NSTAGE(S_NSTAGE),
                      .LOAD_STAGE(S_LOAD)) u_sat (
        .clk   (clk),
        .rst_n (sat_rst_n),
        .bus   (sat_if)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    function automatic exp_t mk(string tag, logic [3:0] mask, logic [31:0] op0,
                                logic [31:0] op1, logic st, logic is,
                                logic [15:0] sc, logic [15:0] fc);
        exp_t e;
        e.tag = tag; e.mask = mask; e.op0 = op0; e.op1 = op1;
        e.stall = st; e.issue = is; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp(string who, exp_t e, logic [31:0] op0, logic [31:0] op1,
                       logic st, logic is, logic [15:0] sc, logic [15:0] fc);
        if (e.mask[0]) chk({who, e.tag, ".op0"}, op0, e.op0);
        if (e.mask[1]) chk({who, e.tag, ".op1"}, op1, e.op1);
        if (e.mask[2]) begin
            chk({who, e.tag, ".stall"}, {31'd0, st}, {31'd0, e.stall});
            chk({who, e.tag, ".issue"}, {31'd0, is}, {31'd0, e.issue});
        end
        if (e.mask[3]) begin
            chk({who, e.tag, ".stall_cnt"}, {16'd0, sc}, {16'd0, e.sc});
            chk({who, e.tag, ".fwd_cnt"}, {16'd0, fc}, {16'd0, e.fc});
        end
    endtask

    // Monitor: compare each queued expectation against the live DUT outputs.
    always @(negedge clk) begin
        if (q_main.size() > 0) begin
            mon_e = q_main.pop_front();
            cmp("main/", mon_e, main_if.op_data[31:0], main_if.op_data[63:32],
                main_if.stall, main_if.issue, main_if.stall_cnt, main_if.fwd_cnt);
        end
        if (q_sat.size() > 0) begin
            mon_e = q_sat.pop_front();
            cmp("sat/", mon_e, {24'd0, sat_if.op_data}, 32'd0,
                sat_if.stall, sat_if.issue, sat_if.stall_cnt, sat_if.fwd_cnt);
        end
    end

    task automatic clr();
        s.rst_n = 1'b1; s.flush = 1'b0; s.valid = 1'b0; s.we = 1'b0; s.ld = 1'b0;
        s.rs0 = 5'd0; s.rs1 = 5'd0; s.rd = 5'd0;
        s.rf0 = 32'd0; s.rf1 = 32'd0; s.sr0 = 32'd0; s.sr1 = 32'd0; s.sr2 = 32'd0;
    endtask

    // Apply the staged inputs just after a rising edge and queue the expectation.
    task automatic cyc(exp_t e);
        @(posedge clk);
        #1;
        main_rst_n              = s.rst_n;
        main_if.flush           = s.flush;
        main_if.id_valid        = s.valid;
        main_if.id_rs           = {s.rs1, s.rs0};
        main_if.id_rd           = s.rd;
        main_if.id_we           = s.we;
        main_if.id_is_load      = s.ld;
        main_if.rf_data         = {s.rf1, s.rf0};
        main_if.stage_result    = {s.sr2, s.sr1, s.sr0};
        q_main.push_back(e);
    endtask

    task automatic run_sat();
        int          n;
        int          sc_m;
        int          fc_m;
        logic        st_m;
        logic [3:0]  mask;
        logic [31:0] op_m;
        exp_t        e;
        n    = 4369 * 16 + 32;
        sc_m = 0;
        fc_m = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                sat_rst_n         = 1'b1;
                sat_if.flush      = 1'b0;
                sat_if.id_valid   = 1'b1;
                sat_if.id_rs      = 5'd3;
                sat_if.id_rd      = 5'd3;
                sat_if.id_we      = 1'b1;
                sat_if.id_is_load = 1'b1;
                sat_if.rf_data    = 8'h5A;
                for (int k = 0; k < S_NSTAGE; k++) begin
                    sat_if.stage_result[k*S_XLEN +: S_XLEN] = 8'(16 + k);
                end
            end
            st_m = ((i % 16) != 0);
            op_m = 32'd0;
            mask = 4'b0000;
            if (i == 0) begin
                mask = M_OP0 | M_SI | M_CNT;
                op_m = 32'h5A;
            end else if (i == 16) begin
                mask = M_OP0 | M_SI | M_CNT;
                op_m = 32'h1F;
            end else if ((i == 1) || (i == 17) || (i == n - 1)) begin
                mask = M_SI | M_CNT;
            end
            e = mk((mask != 4'b0000) ? $sformatf("cycle%0d", i) : "", mask, op_m, 32'd0,
                   st_m, !st_m, 16'(sc_m), 16'(fc_m));
            q_sat.push_back(e);
            if (st_m && (sc_m < 65535)) sc_m++;
            if (!st_m && (i >= 16) && (fc_m < 65535)) fc_m++;
        end
        // One reset edge in the middle of a stall.
        @(posedge clk); #1;
        sat_rst_n = 1'b0;
        q_sat.push_back(mk("reset_held", M_SI, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0, 16'd0));
        @(posedge clk); #1;
        sat_rst_n = 1'b1;
        q_sat.push_back(mk("after_reset", M_OP0 | M_SI | M_CNT, 32'h5A, 32'd0,
                           1'b0, 1'b1, 16'd0, 16'd0));
        @(posedge clk); #1;
        q_sat.push_back(mk("restall", M_SI | M_CNT, 32'd0, 32'd0, 1'b1, 1'b0, 16'd0, 16'd0));
    endtask

    // Watchdog: abort a run that never reaches its summary.
    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed",
                 tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        main_if.flush = 1'b0; main_if.id_valid = 1'b0; main_if.id_rs = '0;
        main_if.id_rd = '0; main_if.id_we = 1'b0; main_if.id_is_load = 1'b0;
        main_if.rf_data = '0; main_if.stage_result = '0;
        sat_if.flush = 1'b0; sat_if.id_valid = 1'b0; sat_if.id_rs = '0;
        sat_if.id_rd = '0; sat_if.id_we = 1'b0; sat_if.id_is_load = 1'b0;
        sat_if.rf_data = '0; sat_if.stage_result = '0;

        clr(); s.rst_n = 1'b0; s.valid = 1'b1; s.rs0 = 5'd2; s.rs1 = 5'd7;
        s.rf0 = 32'h1234; s.rf1 = 32'h5678;
        cyc(mk("reset_rf_pass", M_ALL, 32'h1234, 32'h5678, 1'b0, 1'b0, 16'd0, 16'd0));

        clr(); s.valid = 1'b1; s.rd = 5'd2; s.we = 1'b1;
        cyc(mk("alu_producer", M_ALL, 32'd0, 32'd0, 1'b0, 1'b1, 16'd0, 16'd0));
        clr(); s.valid = 1'b1; s.rs0 = 5'd2; s.rs1 = 5'd9; s.rd = 5'd6;
        s.sr0 = 32'h11; s.rf0 = 32'h99; s.rf1 = 32'h77;
        cyc(mk("alu_chain_ex", M_ALL, 32'h11, 32'h77, 1'b0, 1'b1, 16'd0, 16'd0));
        clr(); s.rs0 = 5'd2; s.sr1 = 32'h22; s.rf0 = 32'h99;
        cyc(mk("fwd_stage1", M_ALL, 32'h22, 32'd0, 1'b0, 1'b0, 16'd0, 16'd1));
        clr(); s.rs0 = 5'd2; s.sr2 = 32'h33; s.rf0 = 32'h99;
        cyc(mk("fwd_wb", M_ALL, 32'h33, 32'd0, 1'b0, 1'b0, 16'd0, 16'd1));
        clr(); s.rs0 = 5'd2; s.rf0 = 32'hDEAD; s.sr0 = 32'hEEEE; s.sr1 = 32'hEEEE; s.sr2 = 32'hEEEE;
        cyc(mk("retired_rf", M_ALL, 32'hDEAD, 32'd0, 1'b0, 1'b0, 16'd0, 16'd1));

        clr(); s.valid = 1'b1; s.rd = 5'd3; s.we = 1'b1; s.ld = 1'b1;
        cyc(mk("load_issue", M_ALL, 32'd0, 32'd0, 1'b0, 1'b1, 16'd0, 16'd1));
        clr(); s.valid = 1'b1; s.rs1 = 5'd3; s.rd = 5'd8; s.we = 1'b1;
        s.sr0 = 32'hBAD; s.sr1 = 32'hAB; s.rf1 = 32'h42;
        cyc(mk("load_use_stall", M_SI | M_CNT, 32'd0, 32'd0, 1'b1, 1'b0, 16'd0, 16'd1));
        cyc(mk("load_use_fwd", M_ALL, 32'd0, 32'hAB, 1'b0, 1'b1, 16'd1, 16'd1));

        clr(); s.valid = 1'b1; s.rd = 5'd4; s.we = 1'b1;
        cyc(mk("dup_first", M_ALL, 32'd0, 32'd0, 1'b0, 1'b1, 16'd1, 16'd2));
        cyc(mk("dup_second", M_ALL, 32'd0, 32'd0, 1'b0, 1'b1, 16'd1, 16'd2));
        clr(); s.valid = 1'b1; s.rs0 = 5'd4; s.rs1 = 5'd8; s.we = 1'b1;
        s.sr0 = 32'h2; s.sr1 = 32'h1; s.sr2 = 32'h888; s.rf0 = 32'h4444; s.rf1 = 32'h8888;
        cyc(mk("dup_youngest", M_ALL, 32'h2, 32'h888, 1'b0, 1'b1, 16'd1, 16'd2));

        clr(); s.valid = 1'b1; s.we = 1'b1; s.rf0 = 32'h55; s.rf1 = 32'h66;
        cyc(mk("rzero_read", M_ALL, 32'd0, 32'd0, 1'b0, 1'b1, 16'd1, 16'd3));
        clr(); s.rs0 = 5'd4; s.sr0 = 32'h11; s.sr1 = 32'h22; s.sr2 = 32'h33;
        cyc(mk("dup_oldest_wb", M_ALL, 32'h33, 32'd0, 1'b0, 1'b0, 16'd1, 16'd3));

        clr(); s.valid = 1'b1; s.rd = 5'd5; s.we = 1'b1; s.ld = 1'b1;
        cyc(mk("load5_issue", M_ALL, 32'd0, 32'd0, 1'b0, 1'b1, 16'd1, 16'd3));
        clr(); s.valid = 1'b1; s.rs0 = 5'd5; s.flush = 1'b1; s.sr0 = 32'hDDDD; s.rf0 = 32'h5555;
        cyc(mk("flush_mid_stall", M_SI | M_CNT, 32'd0, 32'd0, 1'b0, 1'b0, 16'd1, 16'd3));
        clr(); s.valid = 1'b1; s.rs0 = 5'd5; s.rf0 = 32'h5555; s.sr0 = 32'hDDDD; s.sr1 = 32'hEEEE;
        cyc(mk("after_flush_rf", M_ALL, 32'h5555, 32'd0, 1'b0, 1'b1, 16'd1, 16'd3));
        clr();
        cyc(mk("cnt_hold", M_CNT, 32'd0, 32'd0, 1'b0, 1'b0, 16'd1, 16'd3));

        clr(); s.valid = 1'b1; s.rd = 5'd7; s.we = 1'b1; s.ld = 1'b1;
        cyc(mk("load7_issue", M_ALL, 32'd0, 32'd0, 1'b0, 1'b1, 16'd1, 16'd3));
        clr(); s.rst_n = 1'b0; s.valid = 1'b1; s.rs1 = 5'd7; s.rf1 = 32'h7777; s.sr0 = 32'hCCCC;
        cyc(mk("reset_mid_stall", M_ALL, 32'd0, 32'h7777, 1'b0, 1'b0, 16'd1, 16'd3));
        clr(); s.valid = 1'b1; s.rs1 = 5'd7; s.rf1 = 32'h7777; s.sr0 = 32'hCCCC; s.sr1 = 32'hBBBB;
        cyc(mk("post_reset", M_ALL, 32'd0, 32'h7777, 1'b0, 1'b1, 16'd0, 16'd0));

        run_sat();

        @(negedge clk);
        #1;
        chk("queues_drained", 32'(q_main.size() + q_sat.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result data width.
REQ-002 Parameter AW, default 5, register address width; register 0 is hard-wired zero.
REQ-003 Parameter NRP, default 2, number of source-operand read ports.
REQ-004 Parameter NSTAGE, default 3, number of forwarding stages tracked; stage 0 is youngest (EX), stage NSTAGE-1 oldest (WB).
REQ-005 Parameter LOAD_STAGE, default 1, first stage index at which a load result is valid on stage_result; range 0..NSTAGE-1.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 flush  input  1  discard all tracked in-flight writes.
REQ-009 id_valid  input  1  an instruction is presented for issue.
REQ-010 id_rs  input  NRP*AW  source register numbers, port p at bits [p*AW +: AW].
REQ-011 id_rd, id_we, id_is_load  input  AW, 1, 1  destination, write-enable and load flag of the presented instruction.
REQ-012 rf_data  input  NRP*XLEN  register-file read data per port.
REQ-013 stage_result  input  NSTAGE*XLEN  result of the instruction currently in stage k at bits [k*XLEN +: XLEN].
REQ-014 op_data  output  NRP*XLEN  forwarded operand per port.
REQ-015 stall  output  1  presented instruction is not issued this cycle.
REQ-016 issue  output  1  presented instruction is issued this cycle.
REQ-017 stall_cnt, fwd_cnt  output  16, 16  saturating performance counters.

Function
REQ-018 The block SHALL hold a tag pipeline of NSTAGE entries, each {valid, rd, is_load}, advancing one stage every cycle without exception.
REQ-019 Entry k SHALL match port p when valid=1, rd==id_rs[p], rd!=0.
REQ-020 Per port, the youngest (lowest k) matching entry SHALL win; no match or id_rs[p]==0 -> op_data[p]=rf_data[p] (0 when id_rs[p]==0).
REQ-021 The winning entry is ready unless is_load=1 and k<LOAD_STAGE; ready winner -> op_data[p]=stage_result[k]; op_data is combinational, zero-latency.
REQ-022 stall SHALL be 1 when id_valid=1, flush=0, and any port's winner is not ready; otherwise 0.
REQ-023 issue SHALL equal id_valid & ~stall & ~flush.
REQ-024 On each edge: entry k+1 <= entry k; entry 0 <= {id_we & (id_rd!=0), id_rd, id_is_load} when issue=1, else a bubble (valid=0).
REQ-025 A stalled instruction SHALL be re-evaluated next cycle with the advanced tag pipeline; stall SHALL clear no later than LOAD_STAGE cycles after it first asserts.
REQ-026 flush=1 SHALL clear valid in all entries on that edge, block the presented instruction from entry 0, and force stall=0, issue=0.
REQ-027 The oldest entry SHALL retire (leave the pipeline) on the next edge; a write in WB is thereafter visible through rf_data only.
REQ-028 stall_cnt SHALL increment on each cycle with stall=1; fwd_cnt on each cycle with issue=1 and at least one port forwarded; both saturate at 16'hFFFF.
REQ-029 Two entries with the same rd SHALL never both be selected; youngest-first priority resolves duplicates.
REQ-030 Parameters outside range (NSTAGE<1, LOAD_STAGE>=NSTAGE, NRP<1) SHALL be rejected at elaboration.

Reset
REQ-031 rst_n=0 at an edge SHALL clear all entry valid bits, stall_cnt and fwd_cnt to 0, overriding flush and issue; mid-stall reset drops the stall the following cycle.
REQ-032 During and immediately after reset, with no valid entries, op_data=rf_data and stall=id_valid?0:0.

Verification
REQ-033 ALU chain: issue rd=2 (we=1, is_load=0), next cycle id_rs[0]=2, stage_result[0]=0x11 -> op_data[0]=0x11, stall=0, fwd_cnt+1.
REQ-034 Load-use: issue load rd=3, next cycle id_rs[1]=3 -> stall=1 one cycle; following cycle op_data[1]=stage_result[1]=0xAB, issue=1, stall_cnt=1.
REQ-035 Duplicate rd: rd=4 issued twice back-to-back (results 0x1 older, 0x2 younger), then read r4 -> op_data=0x2 from stage 0.
REQ-036 Register zero: issue rd=0, read id_rs=0 with rf_data=0x55 -> op_data=0, no forward, fwd_cnt unchanged.
REQ-037 Flush mid-stall: load rd=5, dependent stalled, flush=1 -> stall=0, issue=0; next cycle read r5 -> op_data=rf_data.
REQ-038 Reset/saturation: preload stall_cnt to 0xFFFF via sustained stall -> holds 0xFFFF; rst_n=0 one edge -> both counters 0, all entries invalid.
